axi_burst_writer: RTL and testbench

AXI_BURST_WRITER -- requirements
Module: axi_burst_writer

---
 rtl/axi_video_pkg.sv | 24 ++
 rtl/axi_burst_writer.sv | 131 +++++++++++++
 tb/tb_axi_burst_writer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_video_pkg.sv
// Shared definitions for the video-memory AXI burst writer: FSM states,
// AXI encodings and the 4 KB burst-boundary check.
package axi_video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [31:0] BOUNDARY_4K = 32'h0000_1000;

    // True when a burst of burst_bytes starting at start_addr has its last byte in the next 4 KB page.
    function automatic logic crosses_4k(input logic [31:0] start_addr, input logic [31:0] burst_bytes);
        logic [31:0] page_offset;
        page_offset = start_addr & (BOUNDARY_4K - 32'd1);
        return (page_offset + burst_bytes) > BOUNDARY_4K;
    endfunction

endpackage

// File: rtl/axi_burst_writer.sv
// Single-outstanding AXI4 INCR burst writer: takes a DMA burst request plus a
// beat stream and drives the AW/W/B channels, reporting completion on done/err.
module axi_burst_writer
    import axi_video_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 18,
    parameter int MAX_BEATS  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [7:0]              req_len,
    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [DATA_WIDTH-1:0]   wd_data,
    input  logic [DATA_WIDTH/8-1:0] wd_strb,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [7:0]              AWLEN,
    output logic [2:0]              AWSIZE,
    output logic [1:0]              AWBURST,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WLAST,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY
);

    localparam int                    ADDR_LSB    = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK   = ~ADDR_WIDTH'((1 << ADDR_LSB) - 1);
    localparam logic [8:0]            MAX_BEATS_C = 9'(MAX_BEATS);

    state_t                  state_r;
    logic [7:0]              beat_cnt_r;
    logic [ADDR_WIDTH-1:0]   aligned_addr_s;
    logic                    accept_s;
    logic                    reject_s;
    logic                    in_data_s;
    logic                    beat_s;
    logic                    resp_err_s;

    // The done cycle keeps req_ready low so back-to-back requests see at least one idle gap.
    assign req_ready      = (state_r == ST_IDLE) && !done;
    assign accept_s       = req_valid && req_ready;
    assign aligned_addr_s = req_addr & ADDR_MASK;
    assign reject_s       = ({1'b0, req_len} >= MAX_BEATS_C) ||
                            crosses_4k(32'(aligned_addr_s), (32'(req_len) + 32'd1) << ADDR_LSB);

    assign AWSIZE  = 3'(ADDR_LSB);
    assign AWBURST = BURST_INCR;

    // W channel is a zero-latency pass-through of the DMA stream while in DATA.
    assign in_data_s = (state_r == ST_DATA);
    assign WVALID    = in_data_s && wd_valid;
    assign wd_ready  = in_data_s && WREADY;
    assign WDATA     = wd_data;
    assign WSTRB     = wd_strb;
    assign WLAST     = in_data_s && (beat_cnt_r == AWLEN);
    assign beat_s    = WVALID && WREADY;

    assign resp_err_s = (BRESP == RESP_SLVERR) || (BRESP == RESP_DECERR);

    // Request FSM with registered AW/B channel controls and completion status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            beat_cnt_r <= 8'd0;
            AWVALID    <= 1'b0;
            AWADDR     <= '0;
            AWLEN      <= 8'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            BREADY     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        beat_cnt_r <= 8'd0;
                        if (reject_s) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            AWADDR  <= aligned_addr_s;
                            AWLEN   <= req_len;
                            AWVALID <= 1'b1;
                            state_r <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (AWREADY) begin
                        AWVALID <= 1'b0;
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_s) begin
                        beat_cnt_r <= beat_cnt_r + 8'd1;
                        if (WLAST) begin
                            BREADY  <= 1'b1;
                            state_r <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (BVALID) begin
                        BREADY  <= 1'b0;
                        done    <= 1'b1;
                        err     <= resp_err_s;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_writer.sv
// Directed bench for axi_burst_writer: hand-computed expectations checked with
// immediate assertions, beats observed by a negedge monitor.
module tb_axi_burst_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [17:0] req_addr;
    logic [7:0]  req_len;
    logic        wd_valid;
    logic        wd_ready;
    logic [63:0] wd_data;
    logic [7:0]  wd_strb;
    logic        done;
    logic        err;
    logic [17:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] beat_data[$];
    logic        beat_last[$];
    int          done_n = 0;
    int          aw_hs_n = 0;

    axi_burst_writer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .done(done), .err(err),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 clk = ~clk;

    // Inputs are stable from #1 after a rising edge, so the negedge sees what the next edge will take.
    always @(negedge clk) begin
        if (WVALID && WREADY) begin
            beat_data.push_back(WDATA);
            beat_last.push_back(WLAST);
        end
        if (done) done_n++;
        if (AWVALID && AWREADY) aw_hs_n++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [17:0] addr, input logic [7:0] len);
        check("req_ready_before_issue", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        tick();
        req_valid = 1'b0;
    endtask

    // Feeds n beats (data 0xD0000000+i); optional WREADY toggling and random wd_valid gaps.
    task automatic drive_beats(input int n, input bit toggle_wready, input bit gaps);
        int  idx = 0;
        int  cyc = 0;
        bit  hs;
        while (idx < n && cyc < 200) begin
            wd_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (toggle_wready) WREADY = ~WREADY;
            else               WREADY = 1'b1;
            wd_data = 64'hD000_0000 + 64'(idx);
            wd_strb = 8'hFF;
            #1;
            hs = wd_valid && wd_ready;
            tick();
            if (hs) idx++;
            cyc++;
        end
        wd_valid = 1'b0;
        WREADY   = 1'b1;
        check("beats_within_budget", 64'(idx), 64'(n));
    endtask

    task automatic check_beats(input string tag, input int base, input int n);
        check({tag, "_count"}, 64'(beat_data.size() - base), 64'(n));
        for (int i = 0; i < n && base + i < beat_data.size(); i++) begin
            check({tag, "_data"}, beat_data[base + i], 64'hD000_0000 + 64'(i));
            check({tag, "_wlast"}, {63'd0, beat_last[base + i]}, (i == n - 1) ? 64'd1 : 64'd0);
        end
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        for (int i = 0; i < 30; i++) begin
            if (done) break;
            tick();
        end
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
        tick();
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int b0;
        int d0;
        int a0;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
        wd_valid = 1'b0; wd_data = '0; wd_strb = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BRESP = 2'b00; BVALID = 1'b0;
        tick(); tick();
        check("rst_awvalid", {63'd0, AWVALID}, 64'd0);
        check("rst_awaddr", 64'(AWADDR), 64'd0);
        check("rst_awlen", 64'(AWLEN), 64'd0);
        check("rst_done_err", {62'd0, done, err}, 64'd0);
        check("rst_bready", {63'd0, BREADY}, 64'd0);
        check("rst_wd_ready", {63'd0, wd_ready}, 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

        // Basic 4-beat burst, all slave readies high.
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
        b0 = beat_data.size();
        issue(18'h00100, 8'd3);
        check("t1_awvalid", {63'd0, AWVALID}, 64'd1);
        check("t1_awaddr", 64'(AWADDR), 64'h100);
        check("t1_awlen", 64'(AWLEN), 64'd3);
        check("t1_awsize", 64'(AWSIZE), 64'd3);
        check("t1_awburst", 64'(AWBURST), 64'd1);
        check("t1_req_ready_busy", {63'd0, req_ready}, 64'd0);
        check("t1_wd_ready_in_addr", {63'd0, wd_ready}, 64'd0);
        drive_beats(4, 1'b0, 1'b0);
        check_beats("t1", b0, 4);
        wait_done("t1", 1'b0);

        // 8 beats with WREADY toggling and random source gaps.
        b0 = beat_data.size();
        issue(18'h00200, 8'd7);
        drive_beats(8, 1'b1, 1'b1);
        check_beats("t2", b0, 8);
        wait_done("t2", 1'b0);

        // Rejections: 4 KB crossing, then length beyond MAX_BEATS.
        a0 = aw_hs_n;
        b0 = beat_data.size();
        issue(18'h00FF8, 8'd1);
        check("t3_done", {63'd0, done}, 64'd1);
        check("t3_err", {63'd0, err}, 64'd1);
        check("t3_no_awvalid", {63'd0, AWVALID}, 64'd0);
        check("t3_req_ready_in_done", {63'd0, req_ready}, 64'd0);
        tick();
        check("t3_done_pulse", {63'd0, done}, 64'd0);
        check("t3_req_ready_after", {63'd0, req_ready}, 64'd1);
        issue(18'h00000, 8'd16);
        check("t3_len_done_err", {62'd0, done, err}, 64'd3);
        check("t3_len_no_awvalid", {63'd0, AWVALID}, 64'd0);
        tick();
        check("t3_no_aw_traffic", 64'(aw_hs_n - a0), 64'd0);
        check("t3_no_beats", 64'(beat_data.size() - b0), 64'd0);

        // 16 beats ending exactly on the 4 KB edge, unaligned start, SLVERR response.
        BRESP = 2'b10;
        b0 = beat_data.size();
        issue(18'h00F84, 8'd15);
        check("t4_awvalid", {63'd0, AWVALID}, 64'd1);
        check("t4_awaddr_aligned", 64'(AWADDR), 64'hF80);
        drive_beats(16, 1'b0, 1'b0);
        check_beats("t4", b0, 16);
        wait_done("t4", 1'b1);
        BRESP = 2'b00;

        // AW stall: address held, no beats move before the AW handshake.
        AWREADY = 1'b0;
        b0 = beat_data.size();
        issue(18'h03040, 8'd2);
        wd_valid = 1'b1; WREADY = 1'b1; wd_data = 64'hD000_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_awvalid_held", {63'd0, AWVALID}, 64'd1);
            check("t5_aw_stable", {38'd0, AWADDR, AWLEN}, {38'd0, 18'h03040, 8'd2});
            check("t5_wd_ready_low", {63'd0, wd_ready}, 64'd0);
        end
        check("t5_no_early_beats", 64'(beat_data.size() - b0), 64'd0);
        AWREADY = 1'b1;
        drive_beats(3, 1'b0, 1'b0);
        check_beats("t5", b0, 3);
        wait_done("t5", 1'b0);

        // Reset after beat 2 of 4: abort with no done, then a clean burst.
        BVALID = 1'b0;
        issue(18'h00400, 8'd3);
        drive_beats(2, 1'b0, 1'b0);
        d0 = done_n;
        rst = 1'b1;
        wd_valid = 1'b1;
        #1;
        check("t6_rst_wvalid", {63'd0, WVALID}, 64'd0);
        check("t6_rst_bready", {63'd0, BREADY}, 64'd0);
        tick();
        check("t6_rst_awvalid", {63'd0, AWVALID}, 64'd0);
        check("t6_rst_aw_regs", {38'd0, AWADDR, AWLEN}, 64'd0);
        check("t6_rst_wlast", {63'd0, WLAST}, 64'd0);
        check("t6_rst_done_err", {62'd0, done, err}, 64'd0);
        wd_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("t6_no_done_pulse", 64'(done_n - d0), 64'd0);
        BVALID = 1'b1;
        b0 = beat_data.size();
        issue(18'h00400, 8'd3);
        drive_beats(4, 1'b0, 1'b0);
        check_beats("t6", b0, 4);
        wait_done("t6", 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
